uart_tx_frame_gen: RTL

UART_TX_FRAME_GEN -- requirements
Module: uart_tx_frame_gen

---
 rtl/uart_tx_frame_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART transmit frame generator (start, data, optional parity, 1/2 stop)
// Optional line-break feature is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame_gen #(
   parameter int   DATA_WIDTH = 8,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
   input  logic                  BREAK,
`endif
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  DATA_ACK
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
   } state_t;

   state_t                state_q, state_n;
   logic                  tx_q, tx_n;
   logic                  ack_q, accept;
   logic [CW-1:0]         cnt_q, cnt_n;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q, par_typ_q, stop2_q;
   logic                  frame_end, can_accept;
`ifdef UART_TX_BREAK_EN
   logic                  break_q, break_n;
`endif

   // Break blocks acceptance both while held and for the cycle that restores the idle level.
`ifdef UART_TX_BREAK_EN
   assign can_accept = !BREAK && !break_q;
`else
   assign can_accept = 1'b1;
`endif

   always_comb begin
      state_n   = state_q;
      tx_n      = tx_q;
      cnt_n     = '0;
      accept    = 1'b0;
      frame_end = 1'b0;
`ifdef UART_TX_BREAK_EN
      break_n   = break_q;
`endif
      case (state_q)
         S_IDLE: begin
            tx_n = IDLE_LEVEL;
`ifdef UART_TX_BREAK_EN
            if (BREAK) begin
               break_n = 1'b1;
               tx_n    = 1'b0;
            end else if (break_q) begin
               break_n = 1'b0;
            end else
`endif
            if (DATA_VALID) begin
               accept  = 1'b1;
               state_n = S_START;
               tx_n    = 1'b0;
            end
         end
         S_START: begin
            state_n = S_DATA;
            tx_n    = data_q[0];
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               if (par_en_q) begin
                  state_n = S_PARITY;
                  tx_n    = (^data_q) ^ par_typ_q;
               end else begin
                  state_n = S_STOP1;
                  tx_n    = 1'b1;
               end
            end else begin
               cnt_n = cnt_q + CW'(1);
               tx_n  = data_q[cnt_n];
            end
         end
         S_PARITY: begin
            state_n = S_STOP1;
            tx_n    = 1'b1;
         end
         S_STOP1: begin
            if (stop2_q) begin
               state_n = S_STOP2;
               tx_n    = 1'b1;
            end else begin
               frame_end = 1'b1;
            end
         end
         S_STOP2: frame_end = 1'b1;
         default: state_n = S_IDLE;
      endcase

      // Back-to-back: the final stop bit is followed directly by the next start bit.
      if (frame_end) begin
         if (DATA_VALID && can_accept) begin
            accept  = 1'b1;
            state_n = S_START;
            tx_n    = 1'b0;
         end else begin
            state_n = S_IDLE;
            tx_n    = IDLE_LEVEL;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         tx_q      <= IDLE_LEVEL;
         ack_q     <= 1'b0;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         stop2_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
         break_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         tx_q    <= tx_n;
         ack_q   <= accept;
         cnt_q   <= cnt_n;
`ifdef UART_TX_BREAK_EN
         break_q <= break_n;
`endif
         if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
         end
      end
   end

   assign TX_OUT   = tx_q;
   assign DATA_ACK = ack_q;
`ifdef UART_TX_BREAK_EN
   assign BUSY     = (state_q != S_IDLE) || break_q;
`else
   assign BUSY     = (state_q != S_IDLE);
`endif

endmodule
